rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one downstream resource among NREQ requesters.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 39 +++
 rtl/rr_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the arbiter state enum and the index-width helper.
package arb_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   // Width of a binary requester index; at least one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set picker: search starts at last+1 and wraps, last is lowest priority.
// Ports: req (request vector), last (pointer) -> onehot, idx, any.
module rr_pick
   import arb_pkg::*;
#(
   parameter int NREQ = 8,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [NREQ-1:0]   first;
   int                sh;
   int                k;
   int                pos;

   always_comb begin
      sh    = int'(last) + 1;
      // Doubled vector makes the right rotation a plain shift, even for sh==NREQ.
      dbl   = {req, req} >> sh;
      rot   = dbl[NREQ-1:0];
      first = rot & (~rot + {{(NREQ-1){1'b0}}, 1'b1});
      k     = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (first[i]) k = i;
      end
      pos    = (k + sh) % NREQ;
      any    = |req;
      idx    = IW'(pos);
      onehot = any ? ({{(NREQ-1){1'b0}}, 1'b1} << pos) : '0;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant; optional hold timeout via ARB_TIMEOUT_EN.
// Ports: clk, rst (async high), req -> gnt, gnt_valid, gnt_idx, preempt.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ     = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   output logic [NREQ-1:0]        gnt,
   output logic                   gnt_valid,
   output logic [idx_w(NREQ)-1:0] gnt_idx,
   output logic                   preempt
);

   localparam int IW = idx_w(NREQ);
   typedef logic [IW-1:0] arb_idx_t;

   arb_state_t      state;
   arb_idx_t        last;
   logic [NREQ-1:0] p_hot;
   arb_idx_t        p_idx;
   logic            p_any;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req    (req),
      .last   (last),
      .onehot (p_hot),
      .idx    (p_idx),
      .any    (p_any)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD) + 1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         last      <= arb_idx_t'(NREQ - 1);
         preempt   <= 1'b0;
         cnt       <= '0;
      end else begin
         preempt <= 1'b0;
         unique case (state)
            IDLE: begin
               if (p_any) begin
                  gnt       <= p_hot;
                  gnt_valid <= 1'b1;
                  gnt_idx   <= p_idx;
                  last      <= p_idx;
                  cnt       <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (!req[gnt_idx]) begin
                  cnt <= '0;
                  if (p_any) begin
                     gnt     <= p_hot;
                     gnt_idx <= p_idx;
                     last    <= p_idx;
                  end else begin
                     gnt       <= '0;
                     gnt_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end else if (cnt == CW'(MAX_HOLD - 1)) begin
                  // Owner is last in search order, so it only wins again when alone.
                  gnt     <= p_hot;
                  gnt_idx <= p_idx;
                  last    <= p_idx;
                  cnt     <= '0;
                  preempt <= (p_idx != gnt_idx);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         last      <= arb_idx_t'(NREQ - 1);
      end else begin
         unique case (state)
            IDLE: begin
               if (p_any) begin
                  gnt       <= p_hot;
                  gnt_valid <= 1'b1;
                  gnt_idx   <= p_idx;
                  last      <= p_idx;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (!req[gnt_idx]) begin
                  if (p_any) begin
                     gnt     <= p_hot;
                     gnt_idx <= p_idx;
                     last    <= p_idx;
                  end else begin
                     gnt       <= '0;
                     gnt_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NREQ=8, MAX_HOLD=4).
// Exercises the timeout path when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic       preempt;

   int checks;
   int failures;
   int e;

   rr_arbiter #(.NREQ(8), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      req      = 8'hFF;

      // 1: reset state, then first grant to index 0
      step();
      step();
      check("rst_gnt", gnt, 8'h00);
      check("rst_valid", gnt_valid, 0);
      check("rst_idx", gnt_idx, 0);
      check("rst_pre", preempt, 0);
      rst = 1'b0;
      step();
      check("t1_gnt", gnt, 8'h01);
      check("t1_idx", gnt_idx, 0);
      check("t1_valid", gnt_valid, 1);
      step();
      step();
      check("t1_hold", gnt, 8'h01);

      // 2: back-to-back handoff, then idle
      req = 8'h05;
      step();
      check("t2_hold", gnt, 8'h01);
      req = 8'h04;
      step();
      check("t2_hand", gnt, 8'h04);
      check("t2_hidx", gnt_idx, 2);
      req = 8'h00;
      step();
      check("t2_idle", gnt, 8'h00);
      check("t2_ival", gnt_valid, 0);
      check("t2_iidx", gnt_idx, 2);
      step();
      check("t2_stay", gnt, 8'h00);

      // 3: fairness with all requesters active
      rst = 1'b1;
      #2;
      rst = 1'b0;
      req = 8'hFF;
      step();
      e = 0;
      check("t3_first", gnt_idx, 0);
      for (int n = 0; n < 8; n++) begin
         req = 8'hFF & ~(8'h01 << e);
         step();
         e = (e + 1) % 8;
         check("t3_next", gnt, 8'h01 << e);
         req = 8'hFF;
         step();
         check("t3_hold", gnt_idx, e);
      end

      // 4: owner 3 releases, wrap to 0, then 3 beats 5
      req = 8'h08;
      step();
      check("t4_own3", gnt, 8'h08);
      req = 8'h09;
      step();
      check("t4_hold3", gnt, 8'h08);
      req = 8'h01;
      step();
      check("t4_wrap", gnt, 8'h01);
      req = 8'h29;
      step();
      check("t4_hold0", gnt, 8'h01);
      req = 8'h28;
      step();
      check("t4_3b5", gnt, 8'h08);

      // 5: async reset between edges while busy
      #2;
      rst = 1'b1;
      #1;
      check("t5_gnt", gnt, 8'h00);
      check("t5_val", gnt_valid, 0);
      step();
      rst = 1'b0;
      step();
      check("t5_rest", gnt, 8'h08);
      check("t5_ridx", gnt_idx, 3);

      // 6: long hold with contention
      rst = 1'b1;
      req = 8'h00;
      #2;
      rst = 1'b0;
      step();
      check("t6_idle", gnt, 8'h00);
      req = 8'h24;
      step();
      check("t6_g0", gnt, 8'h04);
`ifdef ARB_TIMEOUT_EN
      for (int n = 0; n < 3; n++) begin
         step();
         check("t6_held", gnt, 8'h04);
         check("t6_nopre", preempt, 0);
      end
      step();
      check("t6_pgnt", gnt, 8'h20);
      check("t6_pre", preempt, 1);
      step();
      check("t6_pend", preempt, 0);
      check("t6_keep", gnt, 8'h20);
      req = 8'h04;
      step();
      check("t6_solo", gnt, 8'h04);
      for (int n = 0; n < 8; n++) begin
         step();
         check("t6_sgnt", gnt, 8'h04);
         check("t6_spre", preempt, 0);
      end
`else
      for (int n = 0; n < 8; n++) begin
         step();
         check("t6_held", gnt, 8'h04);
         check("t6_nopre", preempt, 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
